// File: rtl/rate_enable_gen.sv
// rate_enable_gen: rate-selectable one-cycle enable strobe with run/step control; ports Clock, Resetn (async active-low), Run/Step (async, synchronized), Speed (rate select) -> Pulse (strobe), Running (FSM in RUN), Beat (toggles per Pulse)
module rate_enable_gen #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int CNT_W = 28
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic       Step,
  input  logic [1:0] Speed,
  output logic       Pulse,
  output logic       Running,
  output logic       Beat
);
  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;
  localparam logic [CNT_W-1:0] R1 = CNT_W'(CLOCK_FREQUENCY - 1);
  localparam logic [CNT_W-1:0] R2 = CNT_W'(2 * CLOCK_FREQUENCY - 1);
  localparam logic [CNT_W-1:0] R3 = CNT_W'(4 * CLOCK_FREQUENCY - 1);
  state_t state, state_n;
  logic run_m, run_s, step_m, step_s, step_q;
  logic [1:0] speed_q;
  logic [CNT_W-1:0] cnt, cnt_n, reload;
  logic pulse_n, step_edge, speed_chg;
  assign Running = state == RUN;
  always_comb begin
    step_edge = step_s & ~step_q;
    speed_chg = Speed != speed_q;
    reload = Speed == 2'b00 ? '0 : Speed == 2'b01 ? R1 : Speed == 2'b10 ? R2 : R3;
    state_n = run_s ? RUN : STOP;
    cnt_n = reload;
    pulse_n = 1'b0;
    if (state == STOP) pulse_n = step_edge;
    else if (run_s && !speed_chg) begin
      pulse_n = cnt == '0;
      cnt_n = cnt == '0 ? reload : cnt - 1'b1;
    end
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state <= STOP;
      cnt <= R1;
      speed_q <= 2'b01;
      {run_m, run_s, step_m, step_s, step_q} <= '0;
      Pulse <= 1'b0;
      Beat <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      speed_q <= Speed;
      {run_m, run_s} <= {Run, run_m};
      {step_m, step_s, step_q} <= {Step, step_m, step_s};
      Pulse <= pulse_n;
      Beat <= Beat ^ pulse_n;
    end
endmodule

// File: tb/tb_rate_enable_gen.sv
// tb_rate_enable_gen: directed and randomized checks of rate_enable_gen against an elapsed-time reference model
module tb_rate_enable_gen;
  localparam int F = 4;
  logic Clock = 0, Resetn = 1, Run = 0, Step = 0;
  logic [1:0] Speed = 2'b01;
  logic Pulse, Running, Beat;
  int checks = 0, passed = 0;
  bit m_r1, m_r2, m_on, m_s1, m_s2, m_s3, m_p, m_b;
  logic [1:0] m_sq;
  int m_el;
  rate_enable_gen #(.CLOCK_FREQUENCY(F), .CNT_W(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Step(Step), .Speed(Speed),
    .Pulse(Pulse), .Running(Running), .Beat(Beat)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  function automatic int div_n(input logic [1:0] s);
    return s == 2'd0 ? 1 : F << (int'(s) - 1);
  endfunction
  task automatic model_reset();
    {m_r1, m_r2, m_on, m_s1, m_s2, m_s3, m_p, m_b} = '0;
    m_sq = 2'b01;
    m_el = 0;
  endtask
  task automatic model_step();
    bit edge_seen = m_s2 && !m_s3;
    if (!m_on) begin
      m_p = edge_seen;
      m_el = 0;
    end else if (!m_r2 || Speed != m_sq) begin
      m_p = 0;
      m_el = 0;
    end else if (m_el == div_n(Speed) - 1) begin
      m_p = 1;
      m_el = 0;
    end else begin
      m_p = 0;
      m_el++;
    end
    m_on = m_r2;
    m_b = m_b ^ m_p;
    {m_r2, m_r1} = {m_r1, Run};
    {m_s3, m_s2, m_s1} = {m_s2, m_s1, Step};
    m_sq = Speed;
  endtask
  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
    check("pulse", Pulse, m_p);
    check("running", Running, m_on);
    check("beat", Beat, m_b);
  endtask
  task automatic wait_pulse(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (Pulse) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic do_reset();
    Resetn = 0;
    #1;
    check("rst_pulse", Pulse, 0);
    check("rst_running", Running, 0);
    check("rst_beat", Beat, 0);
    model_reset();
    repeat (2) @(posedge Clock);
    #1 Resetn = 1;
  endtask
  initial begin
    int n, hi, c8, wraps;
    #3;
    do_reset();
    Run = 1;
    tick(); check("run_lat1", Running, 0);
    tick(); check("run_lat2", Running, 0);
    tick(); check("run_lat3", Running, 1);
    wait_pulse(10, n); check("s01_first", n, 4);
    wait_pulse(10, n); check("s01_gap1", n, 4);
    wait_pulse(10, n); check("s01_gap2", n, 4);
    check("beat_after3", Beat, 1);
    Speed = 2'b11;
    wait_pulse(40, n); check("s11_first", n, 17);
    wait_pulse(40, n); check("s11_gap", n, 16);
    repeat (15) tick();
    Speed = 2'b10;
    tick(); check("switch_no_pulse", Pulse, 0);
    wait_pulse(20, n); check("s10_after_switch", n, 8);
    Run = 0;
    repeat (4) tick();
    check("stopped", Running, 0);
    Step = 1;
    tick(); check("step_k", Pulse, 0);
    tick(); check("step_k1", Pulse, 0);
    tick(); check("step_k2", Pulse, 1);
    tick(); check("step_k3", Pulse, 0);
    tick();
    Step = 0;
    hi = 0;
    repeat (6) begin tick(); hi += int'(Pulse); end
    check("step_single", hi, 0);
    Step = 1;
    wait_pulse(6, n); check("step_second", n, 3);
    Step = 0;
    Speed = 2'b00;
    Run = 1;
    repeat (3) tick();
    check("s00_running", Running, 1);
    tick(); check("s00_first", Pulse, 1);
    hi = 0;
    repeat (8) begin Step = ~Step; tick(); hi += int'(Pulse); end
    check("s00_cont", hi, 8);
    Run = 0;
    repeat (3) tick();
    check("stop_pulse_low", Pulse, 0);
    hi = 0;
    repeat (6) begin tick(); hi += int'(Pulse); end
    check("no_queued_step", hi, 0);
    Speed = 2'b01;
    Run = 1;
    repeat (3) tick();
    wait_pulse(10, n);
    repeat (2) tick();
    #2 do_reset();
    wait_pulse(12, n); check("rst_first_pulse", n, 7);
    Speed = 2'b00;
    wait_pulse(10, n);
    c8 = 0;
    wraps = 0;
    repeat (256) begin
      if (Pulse) begin
        if (c8 == 255) wraps++;
        c8 = (c8 + 1) % 256;
      end
      tick();
    end
    check("wrap_count", wraps, 1);
    check("wrap_final", c8, 0);
    repeat (3000) begin
      if ($urandom_range(39) == 0) Run = ~Run;
      if ($urandom_range(3) == 0) Step = ~Step;
      if ($urandom_range(29) == 0) Speed = 2'($urandom);
      if ($urandom_range(599) == 0) do_reset();
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/rate_enable_gen.md
RATE_ENABLE_GEN -- requirements
Module: rate_enable_gen

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, meaning Clock cycles per second; legal range 1 to 67108863.
REQ-002 SHALL have parameter CNT_W, default 28, meaning the divider counter width; 2^CNT_W SHALL exceed 4*CLOCK_FREQUENCY.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port Run, input, 1 bit: asynchronous level; 1 requests free-running pulses.
REQ-006 SHALL have port Step, input, 1 bit: asynchronous button; a rising edge requests one pulse while stopped.
REQ-007 SHALL have port Speed, input, 2 bits: rate select.
REQ-008 SHALL have port Pulse, output, 1 bit: one-cycle enable strobe that drives the Enable input of the downstream 8-bit counter.
REQ-009 SHALL have port Running, output, 1 bit: 1 when FSM is in RUN.
REQ-010 SHALL have port Beat, output, 1 bit: toggles on every Pulse (LED heartbeat).

Function
REQ-011 Run and Step SHALL each pass through a 2-flop synchronizer; only synchronized versions (run_s, step_s) are used internally.
REQ-012 Step edge SHALL be step_s=1 with its previous registered value 0; each edge is one event.
REQ-013 Divide count N SHALL be: Speed 00 -> 1; 01 -> CLOCK_FREQUENCY; 10 -> 2*CLOCK_FREQUENCY; 11 -> 4*CLOCK_FREQUENCY.
REQ-014 Divider SHALL be a CNT_W-bit down-counter with reload value N-1.
REQ-015 FSM SHALL have two states: STOP (encoding 0) and RUN (encoding 1).
REQ-016 STOP->RUN SHALL occur when run_s=1; RUN->STOP SHALL occur when run_s=0.
REQ-017 On STOP->RUN the divider SHALL load N-1; the first Pulse follows after N cycles in RUN, then one Pulse every N cycles.
REQ-018 In RUN, when the divider is 0 and no reload condition holds, Pulse SHALL be 1 in the next cycle and the divider SHALL reload N-1; otherwise the divider decrements.
REQ-019 At Speed 00 in RUN, Pulse SHALL be 1 every cycle.
REQ-020 In STOP the divider SHALL hold N-1.
REQ-021 In STOP, a Step edge SHALL produce exactly one Pulse cycle, registered one cycle after the edge is detected.
REQ-022 The total latency from Step first sampled high at rising edge k to Pulse high SHALL be the cycle after edge k+2.
REQ-023 Step edges in RUN SHALL be ignored and SHALL NOT be queued.
REQ-024 Pulse SHALL be a registered output and SHALL never be high for two consecutive cycles, except at Speed 00 in RUN.
REQ-025 Speed is sampled every cycle into speed_q; when Speed differs from speed_q the divider SHALL reload the new N-1, and no Pulse SHALL issue that cycle even if the divider was 0.
REQ-026 If RUN->STOP and terminal count coincide, no Pulse SHALL issue.
REQ-027 Beat SHALL invert in the same cycle Pulse is 1.
REQ-028 Running SHALL be registered and equal the FSM state.

Reset
REQ-029 Resetn=0 SHALL asynchronously force STOP, Pulse=0, Running=0, and Beat=0.
REQ-030 Resetn=0 SHALL asynchronously force the divider to CLOCK_FREQUENCY-1 (Speed 01 value), speed_q=01, and all synchronizer and edge flops to 0.
REQ-031 Resetn assertion mid-count or mid-Pulse SHALL take effect immediately, with no Pulse after release until the normal conditions are met.
REQ-032 Deassertion SHALL be synchronized externally; the block takes no action on release beyond resuming normal operation.

Verification (CLOCK_FREQUENCY=4)
REQ-033 Reset then Run=1, Speed=01 held -> Running=1 after 2 synchronizer cycles plus 1 FSM cycle; Pulse on every 4th cycle thereafter, one cycle wide; Beat toggles each Pulse.
REQ-034 Run=1, Speed=11 -> Pulse spacing exactly 16 cycles; switch Speed to 10 with divider at 0 -> no Pulse that cycle, next Pulse 8 cycles later.
REQ-035 Run=0, single Step high for 5 cycles -> exactly one Pulse, high during the cycle after the 3rd rising edge; a second Step edge gives a second Pulse.
REQ-036 Run=1, Speed=00 -> Pulse continuously 1; drive Run=0 -> Pulse low within 3 cycles; Step pulses in RUN produce no extra Pulse.
REQ-037 Resetn pulsed low asynchronously mid-count in RUN -> Pulse, Running, and Beat are 0 immediately; after release with Run=1, the first Pulse is N cycles after re-entering RUN.
REQ-038 Pulse connected to the downstream 8-bit counter Enable, Speed=00, 256 cycles in RUN -> counter wraps from 255 to 0 exactly once.
